sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Shares one sram-like slave between an instruction and a data requester, with in-order response routing.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise data has fixed priority.
//
// state     | meaning
// ST_IDLE   | grant chosen combinationally from the asserted requests
// ST_LOCKED | slave stalled the address phase; grant held on lock_id_q until its handshake
module sram_arbiter #(
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  localparam int PTR_W = $clog2(OUTSTANDING_DEPTH);
  localparam int CNT_W = $clog2(OUTSTANDING_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING_DEPTH - 1);
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } grant_state_e;

  grant_state_e     state_q, state_d;
  logic             lock_id_q, lock_id_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             id_mem_q [OUTSTANDING_DEPTH];
  logic             id_mem_d [OUTSTANDING_DEPTH];

  logic grant_valid;
  logic grant_id;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head_id;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic rr_data_q, rr_data_d;
`endif

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // Grant selection; a held lock always overrides the arbitration policy.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ID_DATA;
    if (state_q == ST_LOCKED) begin
      grant_id    = lock_id_q;
      grant_valid = lock_id_q ? data_sram_req : inst_sram_req;
    end else if (data_sram_req && inst_sram_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      grant_id    = rr_data_q ? ID_DATA : ID_INST;
`else
      grant_id    = ID_DATA;
`endif
      grant_valid = 1'b1;
    end else if (data_sram_req) begin
      grant_id    = ID_DATA;
      grant_valid = 1'b1;
    end else if (inst_sram_req) begin
      grant_id    = ID_INST;
      grant_valid = 1'b1;
    end
    // A full ID FIFO blocks new requests even when a pop frees a slot this cycle.
    if (reset || fifo_full) begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    sram_wr    = 1'b0;
    sram_size  = '0;
    sram_addr  = '0;
    sram_wstrb = '0;
    sram_wdata = '0;
    if (grant_valid) begin
      if (grant_id == ID_DATA) begin
        sram_wr    = data_sram_wr;
        sram_size  = data_sram_size;
        sram_addr  = data_sram_addr;
        sram_wstrb = data_sram_wstrb;
        sram_wdata = data_sram_wdata;
      end else begin
        sram_wr    = inst_sram_wr;
        sram_size  = inst_sram_size;
        sram_addr  = inst_sram_addr;
        sram_wstrb = inst_sram_wstrb;
        sram_wdata = inst_sram_wdata;
      end
    end
  end

  assign sram_req          = grant_valid;
  assign inst_sram_addr_ok = grant_valid && (grant_id == ID_INST) && sram_addr_ok;
  assign data_sram_addr_ok = grant_valid && (grant_id == ID_DATA) && sram_addr_ok;

  assign push    = grant_valid && sram_addr_ok;
  assign pop     = sram_data_ok && !fifo_empty && !reset;
  assign head_id = id_mem_q[rd_ptr_q];

  assign inst_sram_data_ok = pop && (head_id == ID_INST);
  assign data_sram_data_ok = pop && (head_id == ID_DATA);
  assign inst_sram_rdata   = sram_rdata;
  assign data_sram_rdata   = sram_rdata;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !sram_addr_ok) begin
          state_d   = ST_LOCKED;
          lock_id_d = grant_id;
        end
      end
      ST_LOCKED: begin
        // Also release if the locked requester withdraws its request.
        if (push || !grant_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    rr_data_d = rr_data_q;
    if (push) begin
      rr_data_d = (grant_id == ID_INST);
    end
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    id_mem_d = id_mem_q;
    if (push) begin
      id_mem_d[wr_ptr_q] = grant_id;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lock_id_q <= ID_INST;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_data_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_data_q <= rr_data_d;
`endif
    end
  end

  // ID storage needs no reset; entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    id_mem_q <= id_mem_d;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter; expectations follow SRAM_ARB_ROUND_ROBIN_EN when defined.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IA = 32'hBFC0_0100;
  localparam logic [31:0] DA = 32'h1C00_0010;

  always #5 clk = ~clk;

  sram_arbiter #(.OUTSTANDING_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
    .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_addr = IA; inst_sram_wstrb = 4'h0; inst_sram_wdata = 32'h0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_addr = DA; data_sram_wstrb = 4'h0; data_sram_wdata = 32'h0;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  bit [3:0] exp_gnt_data;
  bit [5:0] exp_pop_data;

  initial begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_gnt_data = 4'b0101;
    exp_pop_data = 6'b001010;
`else
    exp_gnt_data = 4'b1111;
    exp_pop_data = 6'b011110;
`endif
    idle();
    reset = 1'b1;
    data_sram_req = 1'b1; sram_addr_ok = 1'b1; sram_data_ok = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_sram_req", sram_req, 1'b0);
    chk("rst_data_addr_ok", data_sram_addr_ok, 1'b0);
    chk("rst_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    chk("rst_data_data_ok", data_sram_data_ok, 1'b0);
    chk("rst_inst_data_ok", inst_sram_data_ok, 1'b0);
    chk("rst_count", dut.count_q, 0);
    idle();
    reset = 1'b0;

    // Single data read
    @(negedge clk);
    data_sram_req = 1'b1; sram_addr_ok = 1'b1;
    #1;
    chk("rd_sram_req", sram_req, 1'b1);
    chk("rd_sram_addr", sram_addr, DA);
    chk("rd_sram_size", sram_size, 2'd2);
    chk("rd_data_addr_ok", data_sram_addr_ok, 1'b1);
    chk("rd_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    @(negedge clk);
    data_sram_req = 1'b0; sram_addr_ok = 1'b0;
    #1;
    chk("rd_idle_sram_req", sram_req, 1'b0);
    chk("rd_idle_sram_addr", sram_addr, 32'h0);
    chk("rd_count1", dut.count_q, 1);
    chk("rd_c1_data_ok", data_sram_data_ok, 1'b0);
    @(negedge clk);
    sram_data_ok = 1'b1; sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_data_ok", data_sram_data_ok, 1'b1);
    chk("rd_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    chk("rd_inst_data_ok", inst_sram_data_ok, 1'b0);
    @(negedge clk);
    sram_data_ok = 1'b0;
    #1;
    chk("rd_count0", dut.count_q, 0);

    // Both requesters with addr_ok every cycle; one-deep pipeline of responses
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      inst_sram_req = (k < 5);
      data_sram_req = (k < 4);
      sram_addr_ok  = (k < 5);
      sram_data_ok  = (k > 0);
      sram_rdata    = 32'h100 + k;
      #1;
      if (k < 4) begin
        chk("arb_data_addr_ok", data_sram_addr_ok, exp_gnt_data[k]);
        chk("arb_inst_addr_ok", inst_sram_addr_ok, !exp_gnt_data[k]);
        chk("arb_sram_addr", sram_addr, exp_gnt_data[k] ? DA : IA);
      end
      if (k == 4) chk("arb_inst_after_drop", inst_sram_addr_ok, 1'b1);
      if (k > 0) begin
        chk("arb_pop_data", data_sram_data_ok, exp_pop_data[k]);
        chk("arb_pop_inst", inst_sram_data_ok, !exp_pop_data[k]);
        chk("arb_rdata", exp_pop_data[k] ? data_sram_rdata : inst_sram_rdata, 32'h100 + k);
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk("arb_count0", dut.count_q, 0);

    // Lock: inst stalled three cycles while data requests
    @(negedge clk);
    inst_sram_req = 1'b1;
    #1;
    chk("lk_c0_addr", sram_addr, IA);
    chk("lk_c0_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      data_sram_req = 1'b1;
      #1;
      chk("lk_held_addr", sram_addr, IA);
      chk("lk_held_data_addr_ok", data_sram_addr_ok, 1'b0);
    end
    @(negedge clk);
    sram_addr_ok = 1'b1;
    #1;
    chk("lk_release_addr", sram_addr, IA);
    chk("lk_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    chk("lk_data_addr_ok0", data_sram_addr_ok, 1'b0);
    @(negedge clk);
    inst_sram_req = 1'b0;
    #1;
    chk("lk_data_next_addr", sram_addr, DA);
    chk("lk_data_addr_ok", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    idle(); sram_data_ok = 1'b1;
    #1;
    chk("lk_pop_inst", inst_sram_data_ok, 1'b1);
    @(negedge clk);
    #1;
    chk("lk_pop_data", data_sram_data_ok, 1'b1);
    @(negedge clk);
    sram_data_ok = 1'b0;
    #1;
    chk("lk_count0", dut.count_q, 0);

    // Full FIFO
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      data_sram_req = 1'b1; sram_addr_ok = 1'b1;
      #1;
      chk("full_fill_addr_ok", data_sram_addr_ok, 1'b1);
    end
    @(negedge clk);
    #1;
    chk("full_count4", dut.count_q, 4);
    chk("full_sram_req0", sram_req, 1'b0);
    chk("full_addr_ok0", data_sram_addr_ok, 1'b0);
    chk("full_sram_addr0", sram_addr, 32'h0);
    @(negedge clk);
    sram_data_ok = 1'b1;
    #1;
    chk("full_pop_req0", sram_req, 1'b0);
    chk("full_pop_data_ok", data_sram_data_ok, 1'b1);
    @(negedge clk);
    #1;
    chk("full_count3", dut.count_q, 3);
    chk("full_reenable", sram_req, 1'b1);
    chk("full_pushpop_addr_ok", data_sram_addr_ok, 1'b1);
    chk("full_pushpop_data_ok", data_sram_data_ok, 1'b1);
    @(negedge clk);
    sram_data_ok = 1'b0;
    #1;
    chk("full_pushpop_count", dut.count_q, 3);
    chk("full_push_addr_ok", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    #1;
    chk("full_count4b", dut.count_q, 4);
    chk("full_sram_req0b", sram_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      data_sram_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1;
      #1;
      chk("full_drain_data_ok", data_sram_data_ok, 1'b1);
    end
    @(negedge clk);
    idle();
    #1;
    chk("full_count0", dut.count_q, 0);

    // Stray response, then reset with two outstanding
    @(negedge clk);
    sram_data_ok = 1'b1;
    #1;
    chk("stray_inst_data_ok", inst_sram_data_ok, 1'b0);
    chk("stray_data_data_ok", data_sram_data_ok, 1'b0);
    @(negedge clk);
    sram_data_ok = 1'b0;
    #1;
    chk("stray_count0", dut.count_q, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      data_sram_req = 1'b1; sram_addr_ok = 1'b1;
      #1;
      chk("rst2_push_addr_ok", data_sram_addr_ok, 1'b1);
    end
    @(negedge clk);
    #1;
    chk("rst2_count2", dut.count_q, 2);
    @(negedge clk);
    idle(); reset = 1'b1; sram_data_ok = 1'b1;
    #1;
    chk("rst2_data_data_ok", data_sram_data_ok, 1'b0);
    chk("rst2_inst_data_ok", inst_sram_data_ok, 1'b0);
    chk("rst2_sram_req", sram_req, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst2_count0", dut.count_q, 0);
    chk("rst2_after_data_ok", data_sram_data_ok, 1'b0);
    @(negedge clk);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
